// File: rtl/controller_poller.sv
// rtl/controller_poller.sv - NES-style multi-pad serial poller with busy/done handshake and one-deep request queue
// Optional CONTROLLER_PRESS_LATCH_EN adds pressed_clr/pressed_out sticky newly-pressed flags.

module controller_poller #(
    parameter int NUM_CONTROLLERS     = 2,
    parameter int BITS_PER_CONTROLLER = 8,
    parameter int CLK_DIV             = 4
) (
    input  logic                                           cpu_clk,
    input  logic                                           rst_B,
    input  logic                                           start_fetch,
    output logic                                           controller_clk,
    output logic                                           controller_latch,
    input  logic [NUM_CONTROLLERS-1:0]                     data_in_B,
    output logic [NUM_CONTROLLERS*BITS_PER_CONTROLLER-1:0] data_out,
    output logic                                           busy,
    output logic                                           done
`ifdef CONTROLLER_PRESS_LATCH_EN
    ,
    input  logic [NUM_CONTROLLERS-1:0]                     pressed_clr,
    output logic [NUM_CONTROLLERS*BITS_PER_CONTROLLER-1:0] pressed_out
`endif
);

    localparam int W  = NUM_CONTROLLERS * BITS_PER_CONTROLLER;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BITS_PER_CONTROLLER > 1) ? $clog2(BITS_PER_CONTROLLER) : 1;

    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_CONTROLLER - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_CLK_HI = 3'd2;
    localparam logic [2:0] S_CLK_LO = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    logic [2:0]                     state;
    logic [PW-1:0]                  phase;
    logic [BW-1:0]                  bit_cnt;
    logic [BITS_PER_CONTROLLER-1:0] shift_q [NUM_CONTROLLERS];
    logic [W-1:0]                   shift_flat;
    logic                           start_q;
    logic                           pending;
    logic                           rise;
    logic                           phase_last;

    assign rise       = start_fetch & ~start_q;
    assign phase_last = (phase == PH_LAST);

    always_comb begin
        shift_flat = '0;
        for (int c = 0; c < NUM_CONTROLLERS; c++)
            shift_flat[c*BITS_PER_CONTROLLER +: BITS_PER_CONTROLLER] = shift_q[c];
    end

    always_ff @(posedge cpu_clk or negedge rst_B) begin
        if (!rst_B) begin
            state            <= S_IDLE;
            phase            <= '0;
            bit_cnt          <= '0;
            start_q          <= 1'b0;
            pending          <= 1'b0;
            controller_clk   <= 1'b0;
            controller_latch <= 1'b0;
            data_out         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            for (int c = 0; c < NUM_CONTROLLERS; c++)
                shift_q[c] <= '0;
        end else begin
            start_q <= start_fetch;
            done    <= 1'b0;
            // UPDATE below overrides this when it consumes the queued request.
            if (rise && state != S_IDLE)
                pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    busy <= rise;
                    if (rise) begin
                        state            <= S_LATCH;
                        phase            <= '0;
                        bit_cnt          <= '0;
                        controller_latch <= 1'b1;
                    end
                end

                S_LATCH: begin
                    if (phase_last) begin
                        phase            <= '0;
                        controller_latch <= 1'b0;
                        for (int c = 0; c < NUM_CONTROLLERS; c++)
                            shift_q[c][0] <= ~data_in_B[c];
                        if (BITS_PER_CONTROLLER == 1) begin
                            state <= S_UPDATE;
                        end else begin
                            state          <= S_CLK_HI;
                            controller_clk <= 1'b1;
                            bit_cnt        <= BW'(1);
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                S_CLK_HI: begin
                    if (phase_last) begin
                        phase          <= '0;
                        controller_clk <= 1'b0;
                        state          <= S_CLK_LO;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                S_CLK_LO: begin
                    if (phase_last) begin
                        phase <= '0;
                        for (int c = 0; c < NUM_CONTROLLERS; c++)
                            shift_q[c][bit_cnt] <= ~data_in_B[c];
                        if (bit_cnt == BIT_LAST) begin
                            state <= S_UPDATE;
                        end else begin
                            bit_cnt        <= bit_cnt + 1'b1;
                            controller_clk <= 1'b1;
                            state          <= S_CLK_HI;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                S_UPDATE: begin
                    data_out <= shift_flat;
                    done     <= 1'b1;
                    if (pending || rise) begin
                        pending          <= 1'b0;
                        state            <= S_LATCH;
                        phase            <= '0;
                        bit_cnt          <= '0;
                        controller_latch <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state            <= S_IDLE;
                    busy             <= 1'b0;
                    controller_clk   <= 1'b0;
                    controller_latch <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONTROLLER_PRESS_LATCH_EN
    logic [W-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        for (int c = 0; c < NUM_CONTROLLERS; c++)
            clr_mask[c*BITS_PER_CONTROLLER +: BITS_PER_CONTROLLER] = {BITS_PER_CONTROLLER{pressed_clr[c]}};
    end

    // Newly-pressed bits are OR'd in after the clear so a same-cycle set survives.
    always_ff @(posedge cpu_clk or negedge rst_B) begin
        if (!rst_B)
            pressed_out <= '0;
        else if (state == S_UPDATE)
            pressed_out <= (pressed_out & ~clr_mask) | (shift_flat & ~data_out);
        else
            pressed_out <= pressed_out & ~clr_mask;
    end
`endif

endmodule

// File: tb/tb_controller_poller.sv
// tb/tb_controller_poller.sv - randomized self-checking bench for controller_poller (two parameter sets)

module tb_controller_poller;

    localparam int N1 = 2, B1 = 8,  D1 = 4, W1 = N1 * B1;
    localparam int N2 = 4, B2 = 12, D2 = 1, W2 = N2 * B2;
    localparam int LAT1 = D1 * (2 * B1 - 1) + 1;
    localparam int LAT2 = D2 * (2 * B2 - 1) + 1;

    int checks = 0;
    int failures = 0;

    logic cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    logic          rst_B = 1'b0;
    logic          sf1 = 1'b0, sf2 = 1'b0;
    logic          ck1, lt1, ck2, lt2;
    logic [N1-1:0] din1;
    logic [N2-1:0] din2;
    logic [W1-1:0] dout1;
    logic [W2-1:0] dout2;
    logic          busy1, done1, busy2, done2;
`ifdef CONTROLLER_PRESS_LATCH_EN
    logic [N1-1:0] clr1 = '0;
    logic [N2-1:0] clr2 = '0;
    logic [W1-1:0] pr1;
    logic [W2-1:0] pr2;
    int            clr_at1 = -1;
    logic [N1-1:0] clr_val1 = '0;
`endif

    controller_poller #(.NUM_CONTROLLERS(N1), .BITS_PER_CONTROLLER(B1), .CLK_DIV(D1)) dut1 (
        .cpu_clk(cpu_clk), .rst_B(rst_B), .start_fetch(sf1),
        .controller_clk(ck1), .controller_latch(lt1), .data_in_B(din1),
        .data_out(dout1), .busy(busy1), .done(done1)
`ifdef CONTROLLER_PRESS_LATCH_EN
        , .pressed_clr(clr1), .pressed_out(pr1)
`endif
    );

    controller_poller #(.NUM_CONTROLLERS(N2), .BITS_PER_CONTROLLER(B2), .CLK_DIV(D2)) dut2 (
        .cpu_clk(cpu_clk), .rst_B(rst_B), .start_fetch(sf2),
        .controller_clk(ck2), .controller_latch(lt2), .data_in_B(din2),
        .data_out(dout2), .busy(busy2), .done(done2)
`ifdef CONTROLLER_PRESS_LATCH_EN
        , .pressed_clr(clr2), .pressed_out(pr2)
`endif
    );

    // Behavioural gamepads: parallel load while latched, advance one button per clock rise.
    logic [B1-1:0] btn1 [N1];
    logic [B2-1:0] btn2 [N2];
    int idx1 = 0, idx2 = 0;
    logic [B1-1:0] t1;
    logic [B2-1:0] t2;

    always @(posedge ck1 or posedge lt1) idx1 <= lt1 ? 0 : idx1 + 1;
    always @(posedge ck2 or posedge lt2) idx2 <= lt2 ? 0 : idx2 + 1;

    always_comb begin
        din1 = '1;
        t1 = '0;
        for (int c = 0; c < N1; c++) begin
            t1 = btn1[c] >> idx1;
            din1[c] = ~t1[0];
        end
    end

    always_comb begin
        din2 = '1;
        t2 = '0;
        for (int c = 0; c < N2; c++) begin
            t2 = btn2[c] >> idx2;
            din2[c] = ~t2[0];
        end
    end

    function automatic logic [W1-1:0] pack1();
        logic [W1-1:0] r = '0;
        for (int c = 0; c < N1; c++) r = r | (W1'(btn1[c]) << (c * B1));
        return r;
    endfunction

    function automatic logic [W2-1:0] pack2();
        logic [W2-1:0] r = '0;
        for (int c = 0; c < N2; c++) r = r | (W2'(btn2[c]) << (c * B2));
        return r;
    endfunction

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // One request on dut1; n counts samples after the edge that sees the rise.
    task automatic poll1(output int lat, output int latch_cnt, output int pulses,
                         output int overlap, output int busy_low);
        logic prev_ck = 1'b0;
        lat = -1; latch_cnt = 0; pulses = 0; overlap = 0; busy_low = 0;
        @(negedge cpu_clk) sf1 = 1'b1;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (n == 1) sf1 = 1'b0;
`ifdef CONTROLLER_PRESS_LATCH_EN
            clr1 = (n == clr_at1) ? clr_val1 : '0;
`endif
            if (lt1) latch_cnt++;
            if (ck1 && !prev_ck) pulses++;
            prev_ck = ck1;
            if (ck1 && lt1) overlap++;
            if (!busy1) busy_low++;
            if (done1) begin
                lat = n;
                break;
            end
        end
        sf1 = 1'b0;
`ifdef CONTROLLER_PRESS_LATCH_EN
        clr1 = '0;
`endif
        tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < N1; c++) btn1[c] = '0;
        for (int c = 0; c < N2; c++) btn2[c] = '0;
        rst_B = 1'b0;
        repeat (3) @(negedge cpu_clk);
        checks++;
        if ({ck1, lt1, busy1, done1, dout1} !== '0) begin
            failures++;
            $display("FAIL reset_dut1 got clk=%b latch=%b busy=%b done=%b data=%h required all zero",
                     ck1, lt1, busy1, done1, dout1);
        end
        checks++;
        if ({ck2, lt2, busy2, done2, dout2} !== '0) begin
            failures++;
            $display("FAIL reset_dut2 got clk=%b latch=%b busy=%b done=%b data=%h required all zero",
                     ck2, lt2, busy2, done2, dout2);
        end
        rst_B = 1'b1;
        repeat (2) @(negedge cpu_clk);
    endtask

    task automatic test_basic();
        int lat, lc, pl, ov, bl;
        logic [W1-1:0] held;
        btn1[0] = 8'h5A;
        btn1[1] = 8'h00;
        poll1(lat, lc, pl, ov, bl);
        checks++;
        if (lat !== LAT1) begin failures++; $display("FAIL basic_latency got=%0d required=%0d", lat, LAT1); end
        checks++;
        if (dout1 !== 16'h005A) begin failures++; $display("FAIL basic_data got=%h required=005a", dout1); end
        checks++;
        if (lc !== D1) begin failures++; $display("FAIL basic_latch_cycles got=%0d required=%0d", lc, D1); end
        checks++;
        if (pl !== B1 - 1) begin failures++; $display("FAIL basic_clk_pulses got=%0d required=%0d", pl, B1 - 1); end
        checks++;
        if (ov !== 0) begin failures++; $display("FAIL basic_clk_latch_overlap got=%0d required=0", ov); end
        checks++;
        if (bl !== 0) begin failures++; $display("FAIL basic_busy_gap got=%0d required=0", bl); end
        checks++;
        if ({busy1, done1} !== 2'b00) begin
            failures++;
            $display("FAIL basic_after_done got busy=%b done=%b required 0 0", busy1, done1);
        end
        held = dout1;
        btn1[0] = 8'hFF;
        repeat (20) tick();
        checks++;
        if (dout1 !== held) begin failures++; $display("FAIL basic_hold got=%h required=%h", dout1, held); end
    endtask

    task automatic test_random();
        int lat, lc, pl, ov, bl;
        logic [W1-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < N1; c++) btn1[c] = B1'($urandom);
            exp = pack1();
            poll1(lat, lc, pl, ov, bl);
            checks++;
            if (lat !== LAT1 || dout1 !== exp) begin
                failures++;
                $display("FAIL random_poll%0d got lat=%0d data=%h required lat=%0d data=%h", i, lat, dout1, LAT1, exp);
            end
            repeat (3) tick();
        end
    endtask

    task automatic test_queue();
        int d_cnt = 0, d1 = -1, d2 = -1, bl = 0;
        logic [W1-1:0] exp_a, exp_b;
        logic [W1-1:0] got_a = '0, got_b = '0;
        for (int c = 0; c < N1; c++) btn1[c] = B1'($urandom);
        exp_a = pack1();
        exp_b = ~exp_a;
        @(negedge cpu_clk) sf1 = 1'b1;
        for (int n = 0; n < 3 * LAT1 + 10; n++) begin
            tick();
            if (n == 1 || n == 18 || n == 26) sf1 = 1'b0;
            if (n == 17 || n == 25) sf1 = 1'b1;
            if (d_cnt < 2 && !busy1) bl++;
            if (done1) begin
                d_cnt++;
                if (d_cnt == 1) begin
                    d1 = n;
                    got_a = dout1;
                    for (int c = 0; c < N1; c++) btn1[c] = ~btn1[c];
                end else if (d_cnt == 2) begin
                    d2 = n;
                    got_b = dout1;
                end
            end
        end
        checks++;
        if (d_cnt !== 2) begin failures++; $display("FAIL queue_done_count got=%0d required=2", d_cnt); end
        checks++;
        if (d1 !== LAT1 || d2 - d1 !== LAT1) begin
            failures++;
            $display("FAIL queue_spacing got first=%0d gap=%0d required first=%0d gap=%0d", d1, d2 - d1, LAT1, LAT1);
        end
        checks++;
        if (bl !== 0) begin failures++; $display("FAIL queue_busy_gap got=%0d required=0", bl); end
        checks++;
        if (got_a !== exp_a || got_b !== exp_b) begin
            failures++;
            $display("FAIL queue_data got=%h,%h required=%h,%h", got_a, got_b, exp_a, exp_b);
        end
        checks++;
        if (busy1 !== 1'b0) begin failures++; $display("FAIL queue_idle_busy got=%b required=0", busy1); end
    endtask

    task automatic test_held();
        int d_cnt = 0;
        @(negedge cpu_clk) sf1 = 1'b1;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (done1) d_cnt++;
        end
        sf1 = 1'b0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (done1) d_cnt++;
        end
        checks++;
        if (d_cnt !== 1) begin failures++; $display("FAIL held_done_count got=%0d required=1", d_cnt); end
    endtask

    task automatic test_reset_mid();
        int lat, lc, pl, ov, bl, waited = 0;
        logic [W1-1:0] exp;
        btn1[0] = 8'hC3;
        btn1[1] = 8'h81;
        poll1(lat, lc, pl, ov, bl);
        @(negedge cpu_clk) sf1 = 1'b1;
        tick();
        sf1 = 1'b0;
        while (!ck1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (ck1 !== 1'b1) begin failures++; $display("FAIL resetmid_reach_clk_hi got clk=%b required=1", ck1); end
        #2 rst_B = 1'b0;
        #1;
        checks++;
        if ({ck1, lt1, busy1, done1, dout1} !== '0) begin
            failures++;
            $display("FAIL resetmid_async got clk=%b latch=%b busy=%b data=%h required all zero", ck1, lt1, busy1, dout1);
        end
        @(negedge cpu_clk) rst_B = 1'b1;
        repeat (2) tick();
        for (int c = 0; c < N1; c++) btn1[c] = B1'($urandom);
        exp = pack1();
        poll1(lat, lc, pl, ov, bl);
        checks++;
        if (lat !== LAT1 || dout1 !== exp) begin
            failures++;
            $display("FAIL resetmid_repoll got lat=%0d data=%h required lat=%0d data=%h", lat, dout1, LAT1, exp);
        end
    endtask

    task automatic test_wide();
        logic [W2-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            int lat = -1;
            for (int c = 0; c < N2; c++) btn2[c] = B2'($urandom);
            if (i == 0) btn2[3] = btn2[3] | 12'h800;
            exp = pack2();
            @(negedge cpu_clk) sf2 = 1'b1;
            for (int n = 0; n < 100; n++) begin
                tick();
                if (n == 1) sf2 = 1'b0;
                if (done2) begin
                    lat = n;
                    break;
                end
            end
            sf2 = 1'b0;
            checks++;
            if (lat !== LAT2 || dout2 !== exp) begin
                failures++;
                $display("FAIL wide_poll%0d got lat=%0d data=%h required lat=%0d data=%h", i, lat, dout2, LAT2, exp);
            end
            if (i == 0) begin
                checks++;
                if (dout2[47] !== 1'b1) begin failures++; $display("FAIL wide_pad3_bit11 got=%b required=1", dout2[47]); end
            end
            repeat (2) tick();
        end
    endtask

`ifdef CONTROLLER_PRESS_LATCH_EN
    task automatic test_pressed();
        int lat, lc, pl, ov, bl;
        logic [W1-1:0] exp_pr, old, nw, mask;
        logic [B1-1:0] seq [7] = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h04, 8'h00, 8'h00};
        logic [N1-1:0] clr_seq [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        @(negedge cpu_clk) clr1 = '1;
        @(negedge cpu_clk) clr1 = '0;
        exp_pr = '0;
        checks++;
        if (pr1 !== '0) begin failures++; $display("FAIL pressed_clear got=%h required=0", pr1); end
        for (int i = 0; i < 7; i++) begin
            old = dout1;
            btn1[0] = (i >= 5) ? B1'($urandom) : seq[i];
            btn1[1] = (i >= 5) ? B1'($urandom) : 8'h00;
            clr_val1 = (i >= 5) ? N1'($urandom) : clr_seq[i];
            clr_at1 = LAT1 - 1;
            nw = pack1();
            mask = '0;
            for (int c = 0; c < N1; c++) if (clr_val1[c]) mask = mask | (W1'({B1{1'b1}}) << (c * B1));
            exp_pr = (exp_pr & ~mask) | (nw & ~old);
            poll1(lat, lc, pl, ov, bl);
            clr_at1 = -1;
            checks++;
            if (pr1 !== exp_pr) begin failures++; $display("FAIL pressed_step%0d got=%h required=%h", i, pr1, exp_pr); end
        end
        checks++;
        if (pr1 === '0 && exp_pr !== '0) begin failures++; $display("FAIL pressed_final got=%h required=%h", pr1, exp_pr); end
    endtask
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_queue();
        test_held();
        test_reset_mid();
        test_wide();
`ifdef CONTROLLER_PRESS_LATCH_EN
        test_pressed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller_poller.md
Name: controller_poller

Overview:
Parametrised successor to the two-pad serial controller interface. Polls NUM_CONTROLLERS shift-register gamepads (NES-style: latch, then clocked serial bits) over a shared controller_clk/controller_latch pair, and presents debounced-per-frame button state to the CPU data mux. The block sits in the cpu_clk domain beside the address bus. The GPU's per-frame controller_start_fetch pulse triggers it. Beyond the fixed 8-bit/2-pad interface it adds configurable pad count, bit count and serial clock rate, a busy/done handshake, one-deep request queueing, and atomic output update.

Parameters:
NUM_CONTROLLERS, 2, number of pads polled in parallel (≥1)
BITS_PER_CONTROLLER, 8, serial bits read per pad per poll (≥1)
CLK_DIV, 4, cpu_clk cycles per controller_clk half-period and per latch pulse (≥1)

Ports:
cpu_clk  input  1  sole clock; all state on rising edge
rst_B  input  1  asynchronous, active-low reset
start_fetch  input  1  poll request; rising edge (sampled in cpu_clk) starts a poll
controller_clk  output  1  shared serial clock to pads, registered
controller_latch  output  1  shared parallel-load strobe to pads, registered
data_in_B  input  NUM_CONTROLLERS  serial data per pad, active-low (1 = not pressed)
data_out  output  NUM_CONTROLLERS*BITS_PER_CONTROLLER  button state; bit c*BITS_PER_CONTROLLER+k = pad c, bit k, 1 = pressed
busy  output  1  high from poll start until done cycle inclusive
done  output  1  one-cycle pulse coinciding with data_out update

Behaviour:
- Reset (rst_B low, async): state IDLE; controller_clk=0, controller_latch=0, data_out=0, busy=0, done=0, pending=0, start_fetch history=0. Reset mid-poll aborts immediately; the partial shift register is discarded.
- Edge detect: start_q registers start_fetch; rise = start_fetch & ~start_q.
- FSM states: IDLE, LATCH, CLK_HI, CLK_LO, UPDATE. Phase counter counts CLK_DIV cycles; bit counter counts 0..BITS_PER_CONTROLLER-1.
- IDLE: on rise → LATCH, busy=1, bit=0.
- LATCH: controller_latch=1 for CLK_DIV cycles. On the last cycle, sample bit 0 of every pad as ~data_in_B into the shift register. If BITS_PER_CONTROLLER=1 → UPDATE, else → CLK_HI.
- CLK_HI: controller_clk=1 for CLK_DIV cycles → CLK_LO.
- CLK_LO: controller_clk=0 for CLK_DIV cycles. Sample the next bit on the last cycle. After the last bit → UPDATE, else → CLK_HI.
- UPDATE (1 cycle): data_out ← shift register (all pads at once, never partially updated); done=1.
  - If pending: clear it, → LATCH, busy stays 1.
  - Otherwise → IDLE, busy=0 the following cycle.
- Latency: rise sampled on edge E0 → data_out/done change on edge E0 + CLK_DIV*(2*BITS_PER_CONTROLLER-1) + 1. Defaults: E0+61.
- Rise while busy (any non-IDLE state, including UPDATE): sets pending. Further rises while pending are dropped (queue depth one).
- start_fetch held high: only one poll; a new poll needs a low→high transition.
- data_out holds its value between polls. controller_clk and controller_latch are never high simultaneously and come straight from flops (no glitches).
- Counter widths: $clog2 of CLK_DIV and of BITS_PER_CONTROLLER, minimum 1 bit.

Optional Feature:
CONTROLLER_PRESS_LATCH_EN
- Defined: adds input pressed_clr [NUM_CONTROLLERS] and output pressed_out [NUM_CONTROLLERS*BITS_PER_CONTROLLER].
  - In UPDATE, pressed_out |= new & ~old_data_out, giving sticky newly-pressed flags.
  - pressed_clr[c] high clears pad c's group at the next edge.
  - If clear and set land in the same cycle, the set wins for newly-pressed bits.
  - pressed_out resets to 0.
- Undefined: neither port exists; no extra flops.

Test Plan:
- Reset then defaults; pad 0 drives bits 0x5A (active-low ~0x5A), pad 1 drives 0x00; pulse start_fetch → latch high cycles 1–4, 7 clk pulses of 4 cycles high; done at E0+61; data_out=16'h005A; busy high through done.
- Rise during CLK_LO of poll 1 → second poll starts the cycle after UPDATE without returning to IDLE; busy continuous; two done pulses 61 cycles apart. A third rise during the same poll is dropped.
- start_fetch held high 200 cycles → exactly one done.
- rst_B low mid-CLK_HI → controller_clk=0, data_out=0, busy=0 asynchronously. After release and a new request, a clean 61-cycle poll.
- NUM_CONTROLLERS=4, BITS_PER_CONTROLLER=12, CLK_DIV=1 → done at E0+24; pad 3 bit 11 lands at data_out[47].
- With CONTROLLER_PRESS_LATCH_EN: poll 0x01 then 0x03 → pressed_out=0x03 then sticky. Assert pressed_clr[0] in the UPDATE cycle of a poll adding 0x04 → pressed_out=0x04.
